dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port data SRAM. It shares the SRAM between the processor load/store path and a host/debug port used for loading test data and dumping results. Fairness is round-robin, with an optional bounded host lock for multi-beat bursts. It drives the SRAM strobes and returns tagged read data one cycle after issue. A stall output freezes the processor PC while its access waits.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SRAM between the CPU load/store path and the host/debug port.
// Round-robin grants, a bounded host lock for bursts, and tagged read return one cycle after issue.
module dmem_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LOCKED    = 2'd1,
    FORCE_CPU = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_t              state_reg, state_next;
  logic                last_host_reg, last_host_next;
  logic [7:0]          lock_cnt_reg, lock_cnt_next;
  logic [7:0]          cnt_inc;
  logic                ret_valid_reg;
  logic                ret_owner_reg;
  logic [DATA_W-1:0]   cpu_rdata_reg;
  logic [DATA_W-1:0]   host_rdata_reg;
  logic                cpu_gnt;
  logic                issue;
  logic                issue_we;

  // Saturating so a lock held with no CPU contention never wraps.
  assign cnt_inc = (lock_cnt_reg >= LOCK_MAX) ? LOCK_MAX : lock_cnt_reg + 8'd1;

  always_comb begin
    cpu_gnt        = 1'b0;
    host_gnt       = 1'b0;
    state_next     = state_reg;
    last_host_next = last_host_reg;
    lock_cnt_next  = lock_cnt_reg;
    case (state_reg)
      ARB: begin
        if (cpu_req && (!host_req || last_host_reg)) begin
          cpu_gnt        = 1'b1;
          last_host_next = 1'b0;
        end else if (host_req) begin
          host_gnt       = 1'b1;
          last_host_next = 1'b1;
          if (host_lock) begin
            lock_cnt_next = 8'd1;
            state_next    = (LOCK_MAX == 8'd1 && cpu_req) ? FORCE_CPU : LOCKED;
          end
        end
      end
      LOCKED: begin
        if (host_req) begin
          host_gnt       = 1'b1;
          last_host_next = 1'b1;
          lock_cnt_next  = cnt_inc;
          if (!host_lock) begin
            state_next    = ARB;
            lock_cnt_next = 8'd0;
          end else if (cnt_inc == LOCK_MAX && cpu_req) begin
            state_next = FORCE_CPU;
          end
        end else begin
          // Host let go of the burst: hand the slot straight to a waiting CPU.
          cpu_gnt = cpu_req;
          if (cpu_req) last_host_next = 1'b0;
          state_next    = ARB;
          lock_cnt_next = 8'd0;
        end
      end
      FORCE_CPU: begin
        if (cpu_req) begin
          cpu_gnt        = 1'b1;
          last_host_next = 1'b0;
        end else if (host_req) begin
          host_gnt       = 1'b1;
          last_host_next = 1'b1;
        end
        state_next    = ARB;
        lock_cnt_next = 8'd0;
      end
      default: begin
        state_next    = ARB;
        lock_cnt_next = 8'd0;
      end
    endcase
  end

  always_comb begin
    issue    = cpu_gnt | host_gnt;
    issue_we = cpu_gnt ? cpu_we : (host_gnt & host_we);
    CEN      = ~issue;
    WEN      = ~(issue & issue_we);
    OEN      = issue & issue_we;
    A        = '0;
    Data2Mem = '0;
    if (cpu_gnt) begin
      A        = cpu_addr;
      Data2Mem = cpu_wdata;
    end else if (host_gnt) begin
      A        = host_addr;
      Data2Mem = host_wdata;
    end
  end

  assign cpu_stall   = cpu_req & ~cpu_gnt;
  assign cpu_rvalid  = ret_valid_reg & ~ret_owner_reg;
  assign host_rvalid = ret_valid_reg & ret_owner_reg;
  // Return data bypasses straight from the SRAM; the registers only hold it afterwards.
  assign cpu_rdata   = cpu_rvalid  ? ReadDataMem : cpu_rdata_reg;
  assign host_rdata  = host_rvalid ? ReadDataMem : host_rdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB;
      last_host_reg  <= 1'b1;
      lock_cnt_reg   <= 8'd0;
      ret_valid_reg  <= 1'b0;
      ret_owner_reg  <= 1'b0;
      cpu_rdata_reg  <= '0;
      host_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      last_host_reg <= last_host_next;
      lock_cnt_reg  <= lock_cnt_next;
      ret_valid_reg <= issue & ~issue_we;
      ret_owner_reg <= host_gnt;
      if (cpu_rvalid)  cpu_rdata_reg  <= ReadDataMem;
      if (host_rvalid) host_rdata_reg <= ReadDataMem;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural SRAM; checks grants, strobes and read return.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_wdata, host_wdata;
  logic          cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic          CEN, WEN, OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] Data2Mem;
  logic [DW-1:0] ReadDataMem = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: registered read, write on CEN=0/WEN=0.
  always @(posedge clk) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= Data2Mem;
      else      ReadDataMem <= mem[A];
    end
  end

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic hr, input logic hw, input logic hl, input logic [AW-1:0] ha,
                       input logic [DW-1:0] hd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
  endtask

  task automatic show(input string name, input int k);
    $display("%s step %0d: cen=%b wen=%b oen=%b a=%0d host_gnt=%b stall=%b crv=%b hrv=%b",
             name, k, CEN, WEN, OEN, A, host_gnt, cpu_stall, cpu_rvalid, host_rvalid);
  endtask

  // Ends on a falling edge with reset released and all requests idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    #1;
    check("rst_cen", CEN, 1);
    check("rst_wen", WEN, 1);
    check("rst_oen", OEN, 0);
    check("rst_a", A, 0);
    check("rst_d2m", Data2Mem, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
    mem[5] = 32'hDEAD_BEEF;
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);

    // Uncontended CPU read of address 5
    do_reset();
    drive(1, 0, 7'd5, '0, 0, 0, 0, '0, '0);
    #1;
    show("t1", 0);
    check("t1_cen", CEN, 0);
    check("t1_wen", WEN, 1);
    check("t1_oen", OEN, 0);
    check("t1_a", A, 5);
    check("t1_stall", cpu_stall, 0);
    @(negedge clk);
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
    #1;
    show("t1", 1);
    check("t1_rvalid", cpu_rvalid, 1);
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("t1_host_rvalid", host_rvalid, 0);
    check("t1_idle_cen", CEN, 1);
    @(negedge clk);
    #1;
    show("t1", 2);
    check("t1_rvalid_drop", cpu_rvalid, 0);
    check("t1_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Both ports read every cycle, no lock: CPU, host, CPU, host...
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 7'd1, '0, 1, 0, 0, 7'd2, '0);
      #1;
      show("t2", k);
      check("t2_host_gnt", host_gnt, k % 2);
      check("t2_stall", cpu_stall, k % 2);
      check("t2_a", A, (k % 2 == 1) ? 2 : 1);
      if (k > 0) begin
        check("t2_cpu_rvalid", cpu_rvalid, ((k - 1) % 2 == 0) ? 1 : 0);
        check("t2_host_rvalid", host_rvalid, ((k - 1) % 2 == 1) ? 1 : 0);
        if ((k - 1) % 2 == 0) check("t2_cpu_rdata", cpu_rdata, init_val(1));
        else                  check("t2_host_rdata", host_rdata, init_val(2));
      end
      @(negedge clk);
    end

    // Host locked write burst to addr 7 while the CPU reads addr 7
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive((k >= 1 && k <= 8), 0, 7'd7, '0, 1, 1, 1, 7'd7, 32'h1122_3344);
      #1;
      show("t3", k);
      check("t3_host_gnt", host_gnt, (k != 8) ? 1 : 0);
      check("t3_stall", cpu_stall, (k >= 1 && k <= 7) ? 1 : 0);
      if (k == 0) begin
        check("t3_wen", WEN, 0);
        check("t3_oen", OEN, 1);
        check("t3_d2m", Data2Mem, 32'h1122_3344);
      end
      if (k == 8) check("t3_cpu_issue_wen", WEN, 1);
      if (k == 9) begin
        check("t3_cpu_rvalid", cpu_rvalid, 1);
        check("t3_cpu_rdata", cpu_rdata, 32'h1122_3344);
      end
      if (k != 9) check("t3_no_cpu_rvalid", cpu_rvalid, 0);
      @(negedge clk);
    end
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);

    // Host back-to-back reads of 0..3
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(0, 0, '0, '0, 1, 0, 0, AW'(k), '0);
      else       drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
      #1;
      show("t4", k);
      check("t4_host_gnt", host_gnt, (k < 4) ? 1 : 0);
      if (k < 4) check("t4_a", A, k);
      check("t4_cpu_rvalid", cpu_rvalid, 0);
      check("t4_host_rvalid", host_rvalid, (k >= 1 && k <= 4) ? 1 : 0);
      if (k >= 1 && k <= 4) check("t4_host_rdata", host_rdata, init_val(k - 1));
      @(negedge clk);
    end

    // Reset the cycle after a CPU read issue drops the return
    do_reset();
    drive(1, 0, 7'd5, '0, 0, 0, 0, '0, '0);
    #1;
    show("t5", 0);
    check("t5_issue_cen", CEN, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
    #1;
    show("t5", 1);
    check("t5_cpu_rvalid", cpu_rvalid, 0);
    check("t5_cpu_rdata", cpu_rdata, 0);
    check("t5_cen", CEN, 1);
    check("t5_a", A, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 7'd9, '0, 1, 0, 0, 7'd10, '0);
    #1;
    show("t5", 2);
    check("t5_cpu_wins_tie", cpu_stall, 0);
    check("t5_host_waits", host_gnt, 0);
    @(negedge clk);
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);

    // Host takes a lock then drops host_req while the CPU waits
    do_reset();
    drive(0, 0, '0, '0, 1, 0, 1, 7'd3, '0);
    #1;
    show("t6", 0);
    check("t6_host_gnt0", host_gnt, 1);
    @(negedge clk);
    drive(1, 0, 7'd4, '0, 0, 0, 1, '0, '0);
    #1;
    show("t6", 1);
    check("t6_cpu_stall1", cpu_stall, 0);
    check("t6_host_gnt1", host_gnt, 0);
    check("t6_a1", A, 4);
    check("t6_host_rvalid1", host_rvalid, 1);
    check("t6_host_rdata1", host_rdata, init_val(3));
    @(negedge clk);
    drive(1, 0, 7'd4, '0, 1, 0, 0, 7'd6, '0);
    #1;
    show("t6", 2);
    check("t6_host_gnt2", host_gnt, 1);
    check("t6_cpu_stall2", cpu_stall, 1);
    check("t6_cpu_rvalid2", cpu_rvalid, 1);
    check("t6_cpu_rdata2", cpu_rdata, init_val(4));
    @(negedge clk);
    drive(1, 0, 7'd4, '0, 1, 0, 0, 7'd6, '0);
    #1;
    show("t6", 3);
    check("t6_host_gnt3", host_gnt, 0);
    check("t6_cpu_stall3", cpu_stall, 0);
    @(negedge clk);
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
